// File: rtl/chan_mux.sv
// N-channel valid/ready multiplexer with a one-entry registered output stage.
// Channels are picked by a fixed select or by a rotating round-robin search.
module chan_mux #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch
);

    localparam logic [SEL_W:0] N_CH_EXT = (SEL_W+1)'(N_CH);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [SEL_W-1:0] ch_reg, ch_next;
    logic [SEL_W-1:0] rr_ptr_reg, rr_ptr_next;

    logic             load_ok;
    logic             cand_valid;
    logic [SEL_W-1:0] cand;
    logic             in_xfer;
    int               rr_idx;

    logic [WIDTH-1:0] ch_data [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
            // rst_n gating keeps every accept low while reset is held
            assign in_ready[gi] = rst_n & load_ok & cand_valid & (cand == SEL_W'(gi));
        end
    endgenerate

    assign load_ok = (state_reg == EMPTY) | out_ready;
    assign in_xfer = cand_valid & load_ok;

    // Round-robin scans from the highest offset down so the nearest valid channel wins
    always_comb begin
        cand_valid = 1'b0;
        cand       = '0;
        rr_idx     = 0;
        if (!mode) begin
            if (({1'b0, sel} < N_CH_EXT) && in_valid[sel]) begin
                cand_valid = 1'b1;
                cand       = sel;
            end
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                rr_idx = (int'(rr_ptr_reg) + k) % N_CH;
                if (in_valid[rr_idx]) begin
                    cand_valid = 1'b1;
                    cand       = SEL_W'(rr_idx);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= EMPTY;
            data_reg   <= '0;
            ch_reg     <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            data_reg   <= data_next;
            ch_reg     <= ch_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        data_next   = data_reg;
        ch_next     = ch_reg;
        rr_ptr_next = rr_ptr_reg;
        if (in_xfer) begin
            state_next = FULL;
            data_next  = ch_data[cand];
            ch_next    = cand;
            if (mode) begin
                rr_ptr_next = (cand == SEL_W'(N_CH - 1)) ? '0 : cand + 1'b1;
            end
        end else if ((state_reg == FULL) && out_ready) begin
            state_next = EMPTY;
        end
    end

    always_comb begin
        out_valid = (state_reg == FULL);
        out_data  = data_reg;
        out_ch    = ch_reg;
    end

endmodule

// File: tb/tb_chan_mux.sv
// Randomized and directed bench for chan_mux: a reference model predicts accepts and
// pushes beats into a scoreboard; a monitor pops and compares on output transfers.
module tb_chan_mux;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [N_CH*WIDTH-1:0] in_data = '0;
    logic [N_CH-1:0]       in_valid = '0;
    logic [N_CH-1:0]       in_ready;
    logic [SEL_W-1:0]      sel = '0;
    logic                  mode = 1'b0;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [SEL_W-1:0]      out_ch;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] c;
    } beat_t;

    beat_t sb_q[$];
    beat_t mon_b;
    bit    model_full = 1'b0;
    int    model_rr   = 0;

    chan_mux #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides the grant from the selection rules.
    task automatic step(input logic [N_CH-1:0] v, input logic [N_CH*WIDTH-1:0] d,
                        input logic [SEL_W-1:0] s, input logic m, input logic r);
        int              g;
        bit              lok;
        logic [N_CH-1:0] exp_rdy;
        beat_t           nb;
        @(posedge clk);
        #2;
        in_valid  = v;
        in_data   = d;
        sel       = s;
        mode      = m;
        out_ready = r;
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, model_full});
        if (model_full && sb_q.size() > 0) begin
            chk("hold_data", {24'd0, out_data}, {24'd0, sb_q[0].d});
            chk("hold_ch", {30'd0, out_ch}, {30'd0, sb_q[0].c});
        end
        g = -1;
        if (!m) begin
            if (int'(s) < N_CH && v[s]) g = int'(s);
        end else begin
            for (int k = 0; k < N_CH; k++)
                if (g < 0 && v[(model_rr + k) % N_CH]) g = (model_rr + k) % N_CH;
        end
        lok = !model_full || r;
        exp_rdy = '0;
        if (g >= 0 && lok) exp_rdy[g] = 1'b1;
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        if (g >= 0 && lok) begin
            nb.d = d[g*WIDTH +: WIDTH];
            nb.c = g[SEL_W-1:0];
            sb_q.push_back(nb);
            model_full = 1'b1;
            if (m) model_rr = (g + 1) % N_CH;
        end else if (r) begin
            model_full = 1'b0;
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
        sb_q.delete();
        model_full = 1'b0;
        model_rr   = 0;
        in_valid   = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got data %0h ch %0d expected no beat", out_data, out_ch);
                end else begin
                    mon_b = sb_q.pop_front();
                    chk("out_data", {24'd0, out_data}, {24'd0, mon_b.d});
                    chk("out_ch", {30'd0, out_ch}, {30'd0, mon_b.c});
                end
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] rv;
        #1 rst_n = 1'b0;
        #1;
        chk("init_out_valid", {31'd0, out_valid}, 32'd0);
        chk("init_in_ready", {28'd0, in_ready}, 32'd0);
        chk("init_out_ch", {30'd0, out_ch}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // fixed select, single valid channel, payload 1 on ch2
        step(4'b0100, 32'h0001_0000, 2'd2, 1'b0, 1'b1);
        step(4'b0000, 32'h0, 2'd2, 1'b0, 1'b1);
        step(4'b0000, 32'h0, 2'd2, 1'b0, 1'b1);

        // round-robin with all channels valid: 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) step(4'hF, $urandom, 2'd0, 1'b1, 1'b1);
        step(4'h0, 32'h0, 2'd0, 1'b1, 1'b1);

        // backpressure: hold for three cycles, then reload in the release cycle
        step(4'hF, $urandom, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(4'hF, $urandom, 2'd0, 1'b1, 1'b0);
        step(4'hF, $urandom, 2'd0, 1'b1, 1'b1);
        step(4'h0, 32'h0, 2'd0, 1'b1, 1'b1);

        // fixed sel pointing at an idle channel drains the output
        step(4'b1011, $urandom, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b1011, $urandom, 2'd2, 1'b0, 1'b1);

        // reset while a beat is held, then round-robin restarts at ch0
        step(4'hF, $urandom, 2'd0, 1'b1, 1'b0);
        step(4'hF, $urandom, 2'd0, 1'b1, 1'b0);
        async_reset();
        step(4'hF, $urandom, 2'd0, 1'b1, 1'b1);
        step(4'h0, 32'h0, 2'd0, 1'b1, 1'b1);

        // mode switch keeps the round-robin pointer
        async_reset();
        step(4'b0010, $urandom, 2'd0, 1'b1, 1'b1);
        step(4'hF, $urandom, 2'd0, 1'b0, 1'b1);
        step(4'hF, $urandom, 2'd0, 1'b0, 1'b1);
        step(4'hF, $urandom, 2'd0, 1'b1, 1'b1);
        step(4'h0, 32'h0, 2'd0, 1'b1, 1'b1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rv = $urandom;
            rd = $urandom;
            step(rv[3:0], rd, rv[5:4], rv[6], (rv[9:8] != 2'b00));
        end

        for (int i = 0; i < 3; i++) step(4'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        chk("drain_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
